// File: rtl/accum_tree_pipe.sv
// Pipelined adder tree: sums N_IN product lanes over L registered stages, then adds
// an external partial sum or the previous result in a final registered stage.
module accum_tree_pipe #(
    parameter int N_IN   = 12,
    parameter int IN_W   = 16,
    parameter int ACC_W  = 32,
    parameter int SIGNED = 0,
    parameter int SAT    = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_IN*IN_W-1:0]   products,
    input  logic [ACC_W-1:0]       partial_sum,
    input  logic                   acc_mode,
    input  logic                   acc_clear,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_W-1:0]       out_sum,
    output logic                   ovf
);

    localparam int L  = $clog2(N_IN);
    localparam int TW = IN_W + L;

    function automatic int level_cnt(input int j);
        int n;
        n = N_IN;
        for (int k = 0; k < j; k++) n = (n + 1) / 2;
        return n;
    endfunction

    // Handshake: a beat moves when in_valid && in_ready; the result moves when
    // out_valid && out_ready. Every stage advances together whenever the output
    // register is not holding an unaccepted result.
    logic advance;
    logic accept;
    assign in_ready = !(out_valid && !out_ready);
    assign advance  = in_ready;
    assign accept   = in_valid && in_ready;

    logic [L:1]       vld_q;
    logic [L:1]       mode_q;
    logic [L:1]       clear_q;
    logic [ACC_W-1:0] psum_q [1:L];

    // Every level is held at the full tree width; sign/zero extension makes the
    // upper bits identical to a level that grows one bit per stage.
    for (genvar j = 0; j <= L; j++) begin : tree
        localparam int CNT = level_cnt(j);
        logic [TW-1:0] lvl_q [CNT];

        if (j == 0) begin : g_in
            for (genvar i = 0; i < N_IN; i++) begin : g_ext
                logic [IN_W-1:0] p;
                assign p = products[i*IN_W +: IN_W];
                assign lvl_q[i] = (SIGNED != 0) ? {{L{p[IN_W-1]}}, p} : {{L{1'b0}}, p};
            end
        end else begin : g_stage
            localparam int PCNT = level_cnt(j - 1);
            logic ld;
            if (j == 1) begin : g_ld_first
                assign ld = accept;
            end else begin : g_ld_next
                assign ld = advance && vld_q[j-1];
            end

            for (genvar i = 0; i < CNT; i++) begin : g_node
                if (2 * i + 1 < PCNT) begin : g_add
                    always_ff @(posedge clk or posedge rst) begin
                        if (rst) lvl_q[i] <= '0;
                        else if (ld) lvl_q[i] <= tree[j-1].lvl_q[2*i] + tree[j-1].lvl_q[2*i+1];
                    end
                end else begin : g_pass
                    always_ff @(posedge clk or posedge rst) begin
                        if (rst) lvl_q[i] <= '0;
                        else if (ld) lvl_q[i] <= tree[j-1].lvl_q[2*i];
                    end
                end
            end
        end
    end

    // Valid bits and the per-beat controls travel alongside the tree data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q   <= '0;
            mode_q  <= '0;
            clear_q <= '0;
            for (int j = 1; j <= L; j++) psum_q[j] <= '0;
        end else if (advance) begin
            vld_q[1] <= in_valid;
            if (in_valid) begin
                psum_q[1]  <= partial_sum;
                mode_q[1]  <= acc_mode;
                clear_q[1] <= acc_clear;
            end
            for (int j = 2; j <= L; j++) begin
                vld_q[j] <= vld_q[j-1];
                if (vld_q[j-1]) begin
                    psum_q[j]  <= psum_q[j-1];
                    mode_q[j]  <= mode_q[j-1];
                    clear_q[j] <= clear_q[j-1];
                end
            end
        end
    end

    logic [TW-1:0]    tree_top;
    logic [ACC_W-1:0] addend;
    logic [ACC_W:0]   t_x;
    logic [ACC_W:0]   a_x;
    logic [ACC_W:0]   sum_x;
    logic             hit;
    logic [ACC_W-1:0] result;

    assign tree_top = tree[L].lvl_q[0];

    // In running mode the addend is the output register itself, so consecutive
    // beats chain without any forwarding path.
    always_comb begin
        addend = mode_q[L] ? (clear_q[L] ? '0 : out_sum) : psum_q[L];
        if (SIGNED != 0) begin
            t_x = {{(ACC_W + 1 - TW){tree_top[TW-1]}}, tree_top};
            a_x = {addend[ACC_W-1], addend};
        end else begin
            t_x = {{(ACC_W + 1 - TW){1'b0}}, tree_top};
            a_x = {1'b0, addend};
        end
        sum_x  = t_x + a_x;
        hit    = (SIGNED != 0) ? (sum_x[ACC_W] ^ sum_x[ACC_W-1]) : sum_x[ACC_W];
        result = sum_x[ACC_W-1:0];
        if (SAT != 0 && hit) begin
            if (SIGNED == 0)        result = '1;
            else if (sum_x[ACC_W])  result = {1'b1, {(ACC_W - 1){1'b0}}};
            else                    result = {1'b0, {(ACC_W - 1){1'b1}}};
        end
    end

    // A new overflow wins over a clearing beat accepted on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            ovf       <= 1'b0;
        end else begin
            if (advance) begin
                out_valid <= vld_q[L];
                if (vld_q[L]) out_sum <= result;
            end
            if (advance && vld_q[L] && hit) ovf <= 1'b1;
            else if (accept && acc_clear)   ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_accum_tree_pipe.sv
// Directed bench for accum_tree_pipe: 12-lane unsigned (wrap and saturate) and a
// 5-lane signed instance, with hand-computed expected results.
module tb_accum_tree_pipe;

    localparam int N_IN = 12;
    localparam int IN_W = 16;
    localparam int ACC_W = 32;
    localparam int NS = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                  in_valid = 1'b0, acc_mode = 1'b0, acc_clear = 1'b0, out_ready = 1'b1;
    logic [N_IN*IN_W-1:0]  products = '0;
    logic [ACC_W-1:0]      partial_sum = '0;
    logic                  w_in_ready, w_out_valid, w_ovf;
    logic [ACC_W-1:0]      w_out_sum;
    logic                  s_in_ready, s_out_valid, s_ovf;
    logic [ACC_W-1:0]      s_out_sum;

    logic                  n_in_valid = 1'b0, n_acc_mode = 1'b0, n_acc_clear = 1'b0, n_out_ready = 1'b1;
    logic [NS*IN_W-1:0]    n_products = '0;
    logic [ACC_W-1:0]      n_partial_sum = '0;
    logic                  n_in_ready, n_out_valid, n_ovf;
    logic [ACC_W-1:0]      n_out_sum;

    int n_vec = 0;
    int n_err = 0;
    logic [ACC_W-1:0] exp_q[$];

    accum_tree_pipe #(.N_IN(N_IN), .IN_W(IN_W), .ACC_W(ACC_W), .SIGNED(0), .SAT(0)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready), .products(products),
        .partial_sum(partial_sum), .acc_mode(acc_mode), .acc_clear(acc_clear),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_sum(w_out_sum), .ovf(w_ovf));

    accum_tree_pipe #(.N_IN(N_IN), .IN_W(IN_W), .ACC_W(ACC_W), .SIGNED(0), .SAT(1)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .products(products),
        .partial_sum(partial_sum), .acc_mode(acc_mode), .acc_clear(acc_clear),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_sum(s_out_sum), .ovf(s_ovf));

    accum_tree_pipe #(.N_IN(NS), .IN_W(IN_W), .ACC_W(ACC_W), .SIGNED(1), .SAT(0)) dut_n (
        .clk(clk), .rst(rst), .in_valid(n_in_valid), .in_ready(n_in_ready), .products(n_products),
        .partial_sum(n_partial_sum), .acc_mode(n_acc_mode), .acc_clear(n_acc_clear),
        .out_valid(n_out_valid), .out_ready(n_out_ready), .out_sum(n_out_sum), .ovf(n_ovf));

    task automatic set_lanes(input logic [IN_W-1:0] v);
        for (int k = 0; k < N_IN; k++) products[k*IN_W +: IN_W] = v;
    endtask

    task automatic idle();
        in_valid = 1'b0; acc_mode = 1'b0; acc_clear = 1'b0; partial_sum = '0; products = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++; if (w_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", w_out_valid); end
        n_vec++; if (w_out_sum !== 32'h0) begin n_err++; $display("FAIL reset_out_sum: got %h want 0", w_out_sum); end
        n_vec++; if (w_ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", w_ovf); end
        n_vec++; if (w_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", w_in_ready); end
        n_vec++; if (n_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_n_out_valid: got %b want 0", n_out_valid); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic exp_v;
        @(negedge clk);
        for (int k = 0; k < N_IN; k++) products[k*IN_W +: IN_W] = 16'(k + 1);
        partial_sum = 32'd100;
        in_valid = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) idle();
            exp_v = (c == 5);
            n_vec++; if (w_out_valid !== exp_v) begin n_err++; $display("FAIL basic_valid c=%0d: got %b want %b", c, w_out_valid, exp_v); end
            if (c == 5) begin
                n_vec++; if (w_out_sum !== 32'd178) begin n_err++; $display("FAIL basic_sum: got %0d want 178", w_out_sum); end
                n_vec++; if (w_ovf !== 1'b0) begin n_err++; $display("FAIL basic_ovf: got %b want 0", w_ovf); end
            end
        end
    endtask

    task automatic test_streaming();
        logic exp_v;
        for (int c = 0; c <= 14; c++) begin
            @(negedge clk);
            if (c >= 1) begin
                exp_v = (c >= 5 && c <= 12);
                n_vec++; if (w_out_valid !== exp_v) begin n_err++; $display("FAIL stream_valid c=%0d: got %b want %b", c, w_out_valid, exp_v); end
                if (exp_v) begin
                    n_vec++; if (w_out_sum !== 32'(12 * (c - 4))) begin n_err++; $display("FAIL stream_sum c=%0d: got %0d want %0d", c, w_out_sum, 12 * (c - 4)); end
                end
            end
            if (c < 8) begin
                set_lanes(16'(c + 1)); partial_sum = '0; in_valid = 1'b1;
            end else idle();
        end
    endtask

    task automatic test_backpressure();
        int sent, got;
        logic [ACC_W-1:0] held, exp_v;
        sent = 0; got = 0; held = '0;
        exp_q.delete();
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            out_ready = !(c >= 7 && c <= 9);
            #1;
            if (w_out_valid && out_ready) begin
                got++;
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++; $display("FAIL bp_extra: got %0d want no output", w_out_sum);
                end else begin
                    exp_v = exp_q.pop_front();
                    n_vec++; if (w_out_sum !== exp_v) begin n_err++; $display("FAIL bp_sum: got %0d want %0d", w_out_sum, exp_v); end
                end
            end
            if (c >= 7 && c <= 9) begin
                n_vec++; if (w_in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready c=%0d: got %b want 0", c, w_in_ready); end
                n_vec++; if (w_out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid c=%0d: got %b want 1", c, w_out_valid); end
                if (c == 7) held = w_out_sum;
                else begin
                    n_vec++; if (w_out_sum !== held) begin n_err++; $display("FAIL bp_hold_sum c=%0d: got %0d want %0d", c, w_out_sum, held); end
                end
            end
            if (sent < 10) begin
                set_lanes(16'(sent + 10)); partial_sum = 32'(sent + 10); in_valid = 1'b1;
                if (w_in_ready) begin exp_q.push_back(32'(13 * (sent + 10))); sent++; end
            end else idle();
        end
        out_ready = 1'b1;
        n_vec++; if (got != 10) begin n_err++; $display("FAIL bp_count: got %0d want 10", got); end
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL bp_missing: got %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_overflow();
        @(negedge clk);
        set_lanes(16'hFFFF); partial_sum = 32'hFFFF_FFFF; in_valid = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) idle();
            if (c == 4) begin
                n_vec++; if (w_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_early: got %b want 0", w_ovf); end
            end
            if (c == 5) begin
                n_vec++; if (w_out_valid !== 1'b1) begin n_err++; $display("FAIL ovf_valid: got %b want 1", w_out_valid); end
                n_vec++; if (w_out_sum !== 32'h000B_FFF3) begin n_err++; $display("FAIL ovf_wrap_sum: got %h want 000bfff3", w_out_sum); end
                n_vec++; if (w_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_wrap_flag: got %b want 1", w_ovf); end
                n_vec++; if (s_out_sum !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL ovf_sat_sum: got %h want ffffffff", s_out_sum); end
                n_vec++; if (s_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_sat_flag: got %b want 1", s_ovf); end
            end
        end
    endtask

    task automatic test_sticky();
        @(negedge clk);
        set_lanes(16'd1); partial_sum = '0; in_valid = 1'b1;
        @(negedge clk);
        idle();
        repeat (4) @(negedge clk);
        n_vec++; if (w_out_sum !== 32'd12) begin n_err++; $display("FAIL sticky_sum: got %0d want 12", w_out_sum); end
        n_vec++; if (w_ovf !== 1'b1) begin n_err++; $display("FAIL sticky_wrap: got %b want 1", w_ovf); end
        n_vec++; if (s_ovf !== 1'b1) begin n_err++; $display("FAIL sticky_sat: got %b want 1", s_ovf); end
    endtask

    task automatic test_accumulate();
        for (int c = 0; c <= 9; c++) begin
            @(negedge clk);
            if (c == 1) begin
                n_vec++; if (w_ovf !== 1'b0) begin n_err++; $display("FAIL acc_clear_ovf: got %b want 0", w_ovf); end
                n_vec++; if (s_ovf !== 1'b0) begin n_err++; $display("FAIL acc_clear_ovf_sat: got %b want 0", s_ovf); end
            end
            if (c >= 5 && c <= 8) begin
                n_vec++; if (w_out_valid !== 1'b1) begin n_err++; $display("FAIL acc_valid c=%0d: got %b want 1", c, w_out_valid); end
                n_vec++; if (w_out_sum !== 32'(12 * (c - 4))) begin n_err++; $display("FAIL acc_sum c=%0d: got %0d want %0d", c, w_out_sum, 12 * (c - 4)); end
            end
            if (c < 4) begin
                set_lanes(16'd1); partial_sum = 32'h0000_DEAD; acc_mode = 1'b1; acc_clear = (c == 0); in_valid = 1'b1;
            end else idle();
        end
    endtask

    task automatic test_signed();
        @(negedge clk);
        n_products = {16'hFFFB, 16'h0004, 16'h0003, 16'hFFFE, 16'hFFFF};
        n_partial_sum = 32'hFFFF_FFF6;
        n_in_valid = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) n_in_valid = 1'b0;
            if (c == 3) begin
                n_vec++; if (n_out_valid !== 1'b0) begin n_err++; $display("FAIL signed_early: got %b want 0", n_out_valid); end
            end
            if (c == 4) begin
                n_vec++; if (n_out_valid !== 1'b1) begin n_err++; $display("FAIL signed_valid: got %b want 1", n_out_valid); end
                n_vec++; if (n_out_sum !== 32'hFFFF_FFF5) begin n_err++; $display("FAIL signed_sum: got %h want fffffff5", n_out_sum); end
                n_vec++; if (n_ovf !== 1'b0) begin n_err++; $display("FAIL signed_ovf: got %b want 0", n_ovf); end
            end
            if (c == 5) begin
                n_vec++; if (n_out_valid !== 1'b0) begin n_err++; $display("FAIL signed_one_shot: got %b want 0", n_out_valid); end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            if (c == 4 || c == 5) begin
                n_vec++; if (n_out_valid !== 1'b1) begin n_err++; $display("FAIL mid_pre_valid c=%0d: got %b want 1", c, n_out_valid); end
                n_vec++; if (n_out_sum !== 32'(c + 1)) begin n_err++; $display("FAIL mid_pre_sum c=%0d: got %0d want %0d", c, n_out_sum, c + 1); end
            end
            if (c < 5) begin
                n_products = {NS{16'd1}}; n_partial_sum = 32'(c); n_in_valid = 1'b1;
            end else n_in_valid = 1'b0;
        end
        #1 rst = 1'b1;
        #1;
        n_vec++; if (n_out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b want 0", n_out_valid); end
        n_vec++; if (n_out_sum !== 32'h0) begin n_err++; $display("FAIL mid_rst_sum: got %0d want 0", n_out_sum); end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_vec++; if (n_out_valid !== 1'b0) begin n_err++; $display("FAIL mid_stale c=%0d: got %b want 0", c, n_out_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_streaming();
        test_backpressure();
        test_overflow();
        test_sticky();
        test_accumulate();
        test_signed();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
